// File: rtl/four_bit_divider_if.sv
// Start/done handshake bundle for the restoring divider.
// master drives operands and start; slave returns results and status.
interface four_bit_divider_if;
  logic       strt_cmpt_i;
  logic [7:0] dividend_i;
  logic [3:0] divisor_i;
  logic [7:0] quotient_o;
  logic [3:0] remainder_o;
  logic       div_zero_o;
  logic       done_o;
  logic       busy_o;
  logic [2:0] state_o;

  modport master (
    output strt_cmpt_i,
    output dividend_i,
    output divisor_i,
    input  quotient_o,
    input  remainder_o,
    input  div_zero_o,
    input  done_o,
    input  busy_o,
    input  state_o
  );

  modport slave (
    input  strt_cmpt_i,
    input  dividend_i,
    input  divisor_i,
    output quotient_o,
    output remainder_o,
    output div_zero_o,
    output done_o,
    output busy_o,
    output state_o
  );
endinterface

// File: rtl/four_bit_divider.sv
// Sequential 8-by-4 restoring divider, one quotient bit per clock.
// Shares the start/done/state handshake of the shift-add multiplier.
module four_bit_divider (
  input  logic               clk_i,
  input  logic               rst_i,
  four_bit_divider_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIVIDE = 3'd1,
    ST_END    = 3'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;

  logic [7:0] r_dvd;
  logic [7:0] w_dvd_nx;
  logic [3:0] r_dsr;
  logic [3:0] w_dsr_nx;
  // Partial remainder always stays below the divisor, so 4 bits hold it.
  logic [3:0] r_rem;
  logic [3:0] w_rem_nx;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nx;

  logic [7:0] r_quo;
  logic [7:0] w_quo_nx;
  logic [3:0] r_rmd;
  logic [3:0] w_rmd_nx;
  logic       r_dz;
  logic       w_dz_nx;
  logic       r_done;
  logic       w_done_nx;

  logic [4:0] w_trial;
  logic       w_ge;
  logic [3:0] w_rem_step;
  logic [7:0] w_dvd_step;

  // Trial subtraction: bring down the next dividend bit.
  assign w_trial    = {r_rem, r_dvd[7]};
  assign w_ge       = (w_trial >= {1'b0, r_dsr});
  assign w_rem_step = w_ge ? 4'(w_trial - {1'b0, r_dsr})
                           : w_trial[3:0];
  assign w_dvd_step = {r_dvd[6:0], w_ge};

  assign bus.quotient_o  = r_quo;
  assign bus.remainder_o = r_rmd;
  assign bus.div_zero_o  = r_dz;
  assign bus.done_o      = r_done;
  assign bus.busy_o      = (r_state != ST_IDLE);
  assign bus.state_o     = r_state;

  // Next-state and next-register values for every FSM state.
  always_comb begin
    w_state_nx = r_state;
    w_dvd_nx   = r_dvd;
    w_dsr_nx   = r_dsr;
    w_rem_nx   = r_rem;
    w_cnt_nx   = r_cnt;
    w_quo_nx   = r_quo;
    w_rmd_nx   = r_rmd;
    w_dz_nx    = r_dz;
    w_done_nx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.strt_cmpt_i) begin
          if (bus.divisor_i == 4'd0) begin
            w_quo_nx   = 8'hFF;
            w_rmd_nx   = 4'hF;
            w_dz_nx    = 1'b1;
            w_done_nx  = 1'b1;
            w_state_nx = ST_END;
          end else begin
            w_dvd_nx   = bus.dividend_i;
            w_dsr_nx   = bus.divisor_i;
            w_rem_nx   = 4'd0;
            w_cnt_nx   = 3'd7;
            w_state_nx = ST_DIVIDE;
          end
        end
      end
      ST_DIVIDE: begin
        w_dvd_nx = w_dvd_step;
        w_rem_nx = w_rem_step;
        if (r_cnt == 3'd0) begin
          w_quo_nx   = w_dvd_step;
          w_rmd_nx   = w_rem_step;
          w_dz_nx    = 1'b0;
          w_done_nx  = 1'b1;
          w_state_nx = ST_END;
        end else begin
          w_cnt_nx = r_cnt - 3'd1;
        end
      end
      ST_END: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State register and datapath registers, cleared by async reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_dvd   <= 8'd0;
      r_dsr   <= 4'd0;
      r_rem   <= 4'd0;
      r_cnt   <= 3'd0;
      r_quo   <= 8'd0;
      r_rmd   <= 4'd0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_dvd   <= w_dvd_nx;
      r_dsr   <= w_dsr_nx;
      r_rem   <= w_rem_nx;
      r_cnt   <= w_cnt_nx;
      r_quo   <= w_quo_nx;
      r_rmd   <= w_rmd_nx;
      r_dz    <= w_dz_nx;
      r_done  <= w_done_nx;
    end
  end

endmodule

// File: tb/tb_four_bit_divider.sv
// Self-checking bench for four_bit_divider against an arithmetic model.
// Scenario tasks run in sequence from one initial block.
module tb_four_bit_divider;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   cyc;

  four_bit_divider_if bus ();

  four_bit_divider dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ref_q(input int a, input int b);
    return (b == 0) ? 8'hFF : 8'(a / b);
  endfunction

  function automatic logic [3:0] ref_r(input int a, input int b);
    return (b == 0) ? 4'hF : 4'(a % b);
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.state_o !== 3'd0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (bus.state_o !== 3'd0) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout state=%0d want 0", bus.state_o);
    end
  endtask

  // Pulse start for one cycle; return edges from E0 until done seen.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        output int edges);
    wait_idle();
    @(negedge clk);
    bus.dividend_i  = a;
    bus.divisor_i   = b;
    bus.strt_cmpt_i = 1'b1;
    @(posedge clk); #1;
    bus.strt_cmpt_i = 1'b0;
    edges = 1;
    while (bus.done_o !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    if (bus.done_o !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout a=%0d b=%0d", a, b);
      edges = -1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.strt_cmpt_i = 1'b0;
    bus.dividend_i  = 8'd0;
    bus.divisor_i   = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.quotient_o, bus.remainder_o, bus.div_zero_o,
         bus.done_o, bus.busy_o, bus.state_o} !== 20'd0) begin
      n_err++;
      $display("FAIL reset q=%0d r=%0d dz=%b d=%b b=%b s=%0d want all 0",
               bus.quotient_o, bus.remainder_o, bus.div_zero_o,
               bus.done_o, bus.busy_o, bus.state_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    wait_idle();
    @(negedge clk);
    bus.dividend_i  = 8'd200;
    bus.divisor_i   = 4'd7;
    bus.strt_cmpt_i = 1'b1;
    @(posedge clk); #1;
    bus.strt_cmpt_i = 1'b0;
    n_vec++;
    if (bus.state_o !== 3'd1) begin
      n_err++;
      $display("FAIL basic_state_e0 got=%0d want=1", bus.state_o);
    end
    for (int j = 0; j <= 9; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      n_vec++;
      if (bus.done_o !== (j == 8)) begin
        n_err++;
        $display("FAIL basic_done e%0d got=%b want=%b",
                 j, bus.done_o, (j == 8));
      end
      n_vec++;
      if (bus.busy_o !== (j <= 8)) begin
        n_err++;
        $display("FAIL basic_busy e%0d got=%b want=%b",
                 j, bus.busy_o, (j <= 8));
      end
    end
    n_vec++;
    if (bus.quotient_o !== 8'd28 || bus.remainder_o !== 4'd4 ||
        bus.div_zero_o !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result got=%0d r%0d dz=%b want=28 r4 dz=0",
               bus.quotient_o, bus.remainder_o, bus.div_zero_o);
    end
    n_vec++;
    if (bus.state_o !== 3'd0) begin
      n_err++;
      $display("FAIL basic_state_e9 got=%0d want=0", bus.state_o);
    end
  endtask

  task automatic test_sweep_held();
    logic [7:0] da [5] = '{8'd255, 8'd255, 8'd9, 8'd0, 8'd15};
    logic [3:0] db [5] = '{4'd1, 4'd15, 4'd10, 4'd5, 4'd15};
    int last;
    int k;
    wait_idle();
    @(negedge clk);
    bus.dividend_i  = da[0];
    bus.divisor_i   = db[0];
    bus.strt_cmpt_i = 1'b1;
    last = 0;
    for (int i = 0; i < 5; i++) begin
      k = 0;
      do begin
        @(posedge clk); #1;
        k++;
      end while (bus.done_o !== 1'b1 && k < 30);
      n_vec++;
      if (bus.done_o !== 1'b1 ||
          bus.quotient_o !== ref_q(da[i], db[i]) ||
          bus.remainder_o !== ref_r(da[i], db[i])) begin
        n_err++;
        $display("FAIL sweep %0d/%0d got=%0d r%0d want=%0d r%0d",
                 da[i], db[i], bus.quotient_o, bus.remainder_o,
                 ref_q(da[i], db[i]), ref_r(da[i], db[i]));
      end
      if (i > 0) begin
        n_vec++;
        if (cyc - last !== 10) begin
          n_err++;
          $display("FAIL sweep_spacing op%0d got=%0d want=10",
                   i, cyc - last);
        end
      end
      last = cyc;
      if (i < 4) begin
        bus.dividend_i = da[i+1];
        bus.divisor_i  = db[i+1];
      end
    end
    bus.strt_cmpt_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_div_zero();
    int e;
    wait_idle();
    @(negedge clk);
    bus.dividend_i  = 8'd100;
    bus.divisor_i   = 4'd0;
    bus.strt_cmpt_i = 1'b1;
    @(posedge clk); #1;
    bus.strt_cmpt_i = 1'b0;
    n_vec++;
    if (bus.done_o !== 1'b1 || bus.quotient_o !== 8'hFF ||
        bus.remainder_o !== 4'hF || bus.div_zero_o !== 1'b1) begin
      n_err++;
      $display("FAIL divzero d=%b q=%h r=%h dz=%b want 1 ff f 1",
               bus.done_o, bus.quotient_o, bus.remainder_o,
               bus.div_zero_o);
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.done_o !== 1'b0 || bus.state_o !== 3'd0) begin
      n_err++;
      $display("FAIL divzero_end d=%b s=%0d want 0 0",
               bus.done_o, bus.state_o);
    end
    run_op(8'd100, 4'd3, e);
    n_vec++;
    if (e !== 9 || bus.quotient_o !== 8'd33 ||
        bus.remainder_o !== 4'd1 || bus.div_zero_o !== 1'b0) begin
      n_err++;
      $display("FAIL divzero_clear e=%0d q=%0d r=%0d dz=%b want 9 33 1 0",
               e, bus.quotient_o, bus.remainder_o, bus.div_zero_o);
    end
  endtask

  task automatic test_ignore_start();
    int pulses;
    logic [7:0] q;
    logic [3:0] r;
    wait_idle();
    @(negedge clk);
    bus.dividend_i  = 8'd200;
    bus.divisor_i   = 4'd7;
    bus.strt_cmpt_i = 1'b1;
    @(posedge clk); #1;
    bus.strt_cmpt_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.dividend_i  = 8'd13;
    bus.divisor_i   = 4'd2;
    bus.strt_cmpt_i = 1'b1;
    @(posedge clk); #1;
    bus.strt_cmpt_i = 1'b0;
    pulses = 0;
    q = 8'd0;
    r = 4'd0;
    for (int j = 0; j < 14; j++) begin
      @(posedge clk); #1;
      if (bus.done_o === 1'b1) begin
        pulses++;
        q = bus.quotient_o;
        r = bus.remainder_o;
      end
    end
    n_vec++;
    if (pulses !== 1 || q !== 8'd28 || r !== 4'd4) begin
      n_err++;
      $display("FAIL ignore_start pulses=%0d q=%0d r=%0d want 1 28 4",
               pulses, q, r);
    end
  endtask

  task automatic test_async_reset();
    int e;
    wait_idle();
    @(negedge clk);
    bus.dividend_i  = 8'd200;
    bus.divisor_i   = 4'd7;
    bus.strt_cmpt_i = 1'b1;
    @(posedge clk); #1;
    bus.strt_cmpt_i = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.quotient_o, bus.remainder_o, bus.div_zero_o,
         bus.done_o, bus.busy_o, bus.state_o} !== 20'd0) begin
      n_err++;
      $display("FAIL async_reset q=%0d r=%0d b=%b s=%0d want all 0",
               bus.quotient_o, bus.remainder_o, bus.busy_o, bus.state_o);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(8'd50, 4'd6, e);
    n_vec++;
    if (e !== 9 || bus.quotient_o !== 8'd8 || bus.remainder_o !== 4'd2) begin
      n_err++;
      $display("FAIL post_reset e=%0d q=%0d r=%0d want 9 8 2",
               e, bus.quotient_o, bus.remainder_o);
    end
  endtask

  task automatic test_round_trip();
    int e;
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        run_op(8'(a * b), 4'(b), e);
        n_vec++;
        if (bus.quotient_o !== 8'(a) || bus.remainder_o !== 4'd0) begin
          n_err++;
          $display("FAIL round_trip %0d*%0d/%0d got=%0d r%0d",
                   a, b, b, bus.quotient_o, bus.remainder_o);
        end
      end
    end
  endtask

  task automatic test_exhaustive();
    int e;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(8'(a), 4'(b), e);
        n_vec++;
        if (bus.quotient_o !== ref_q(a, b) ||
            bus.remainder_o !== ref_r(a, b) ||
            bus.div_zero_o !== (b == 0) ||
            e !== ((b == 0) ? 1 : 9)) begin
          n_err++;
          $display("FAIL exhaustive %0d/%0d got=%0d r%0d dz=%b e=%0d",
                   a, b, bus.quotient_o, bus.remainder_o,
                   bus.div_zero_o, e);
        end
      end
    end
  endtask

  task automatic test_random();
    int e;
    logic [7:0] a;
    logic [3:0] b;
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_op(a, b, e);
      n_vec++;
      if (bus.quotient_o !== ref_q(a, b) ||
          bus.remainder_o !== ref_r(a, b) ||
          bus.div_zero_o !== (b == 4'd0)) begin
        n_err++;
        $display("FAIL random %0d/%0d got=%0d r%0d dz=%b",
                 a, b, bus.quotient_o, bus.remainder_o, bus.div_zero_o);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    test_reset();
    test_basic();
    test_sweep_held();
    test_div_zero();
    test_ignore_start();
    test_async_reset();
    test_round_trip();
    test_exhaustive();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
